// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - Sequential 32-cycle multiply/divide unit with HI/LO registers and EX-stage stall control.
module muldiv_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [5:0]  funct,
  input  logic [31:0] rdata1,
  input  logic [31:0] rdata2,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hilo_out,
  output logic        div_zero
);
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, state_nxt;

  logic [31:0] hi, lo;
  logic [31:0] acc;      // partial product high word / partial remainder
  logic [31:0] qm;       // multiplier being shifted out / quotient being shifted in
  logic [31:0] opb;      // multiplicand / divisor magnitude
  logic [4:0]  cnt;
  logic        is_div, res_neg, rem_neg, dz;

  logic        is_muldiv, is_mf, accept, signed_op;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, div_shift, div_diff;
  logic [63:0] prod, prod_fix;
  logic [31:0] quo_fix, rem_fix;

  assign is_muldiv = (funct == F_MULT) || (funct == F_MULTU) ||
                     (funct == F_DIV)  || (funct == F_DIVU);
  assign is_mf     = (funct == F_MFHI) || (funct == F_MFLO);
  assign accept    = (state == IDLE) && valid && is_muldiv;
  assign signed_op = ~funct[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (cnt == 5'd31) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    stall    = valid && busy && (is_muldiv || is_mf);
    hilo_out = (funct == F_MFHI) ? hi : lo;
  end

  assign a_mag = (signed_op && rdata1[31]) ? -rdata1 : rdata1;
  assign b_mag = (signed_op && rdata2[31]) ? -rdata2 : rdata2;

  // One shift-add and one restoring shift-subtract step; the op kind picks which is kept.
  assign mul_sum   = {1'b0, acc} + (qm[0] ? {1'b0, opb} : 33'd0);
  assign div_shift = {acc, qm[31]};
  assign div_diff  = div_shift - {1'b0, opb};

  assign prod     = {acc, qm};
  assign prod_fix = res_neg ? -prod : prod;
  // With a zero divisor the restoring loop leaves the dividend magnitude as remainder,
  // so re-applying the dividend sign restores the raw operand.
  assign quo_fix  = dz ? 32'hFFFF_FFFF : (res_neg ? -qm : qm);
  assign rem_fix  = rem_neg ? -acc : acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi       <= 32'd0;
      lo       <= 32'd0;
      acc      <= 32'd0;
      qm       <= 32'd0;
      opb      <= 32'd0;
      cnt      <= 5'd0;
      is_div   <= 1'b0;
      res_neg  <= 1'b0;
      rem_neg  <= 1'b0;
      dz       <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            acc     <= 32'd0;
            qm      <= a_mag;
            opb     <= b_mag;
            cnt     <= 5'd0;
            is_div  <= funct[1];
            res_neg <= signed_op && (rdata1[31] ^ rdata2[31]);
            rem_neg <= signed_op && rdata1[31];
            dz      <= funct[1] && (rdata2 == 32'd0);
          end
        end
        RUN: begin
          cnt <= cnt + 5'd1;
          if (is_div) begin
            acc <= div_diff[32] ? div_shift[31:0] : div_diff[31:0];
            qm  <= {qm[30:0], ~div_diff[32]};
          end else begin
            acc <= mul_sum[32:1];
            qm  <= {mul_sum[0], qm[31:1]};
          end
        end
        FIX: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[63:32];
            lo <= prod_fix[31:0];
          end
          div_zero <= dz;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - Directed self-checking bench for muldiv_sequencer.
module tb_muldiv_sequencer;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;

  logic        clk = 1'b0;
  logic        rst, valid;
  logic [5:0]  funct;
  logic [31:0] rdata1, rdata2;
  logic        stall, busy, div_zero;
  logic [31:0] hilo_out;

  int n_cmp = 0;
  int n_bad = 0;
  int n;

  always #5 clk = ~clk;

  muldiv_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .valid    (valid),
    .funct    (funct),
    .rdata1   (rdata1),
    .rdata2   (rdata2),
    .stall    (stall),
    .busy     (busy),
    .hilo_out (hilo_out),
    .div_zero (div_zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 100) begin
      cycles++;
      tick();
    end
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
    valid = 1'b1;
    funct = F_MFHI;
    #1;
    check({tag, " stall"}, {31'd0, stall}, 32'd0);
    check({tag, " hi"}, hilo_out, ehi);
    funct = F_MFLO;
    #1;
    check({tag, " lo"}, hilo_out, elo);
    valid = 1'b0;
    funct = 6'd0;
  endtask

  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edz);
    int cyc;
    valid  = 1'b1;
    funct  = f;
    rdata1 = a;
    rdata2 = b;
    tick();
    valid  = 1'b0;
    funct  = 6'd0;
    rdata1 = $urandom;
    rdata2 = $urandom;
    wait_idle(cyc);
    check({tag, " latency"}, cyc, 32'd33);
    check({tag, " div_zero"}, {31'd0, div_zero}, {31'd0, edz});
    read_hilo(tag, ehi, elo);
    tick();
    check({tag, " div_zero end"}, {31'd0, div_zero}, 32'd0);
  endtask

  initial begin
    rst    = 1'b1;
    valid  = 1'b1;
    funct  = F_MULT;
    rdata1 = 32'd5;
    rdata2 = 32'd6;
    tick();
    tick();
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset stall", {31'd0, stall}, 32'd0);
    check("reset div_zero", {31'd0, div_zero}, 32'd0);
    check("reset hilo", hilo_out, 32'd0);
    valid = 1'b0;
    funct = 6'd0;
    rst   = 1'b0;

    run_op("multu max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult -3x7", F_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("div -7/2",  F_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu 100/0", F_DIVU, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
    run_op("div -5/0",  F_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
    run_op("div min/-1", F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);

    // MULT followed immediately by a dependent MFLO
    valid  = 1'b1;
    funct  = F_MULT;
    rdata1 = 32'd6;
    rdata2 = 32'd7;
    tick();
    funct = F_MFLO;
    n = 0;
    while (stall && n < 100) begin
      n++;
      tick();
    end
    check("mflo stall cycles", n, 32'd33);
    check("mflo stall end", {31'd0, stall}, 32'd0);
    check("mflo value", hilo_out, 32'd42);
    valid = 1'b0;
    funct = 6'd0;
    tick();

    // Back-to-back DIVU: the second waits for IDLE
    valid  = 1'b1;
    funct  = F_DIVU;
    rdata1 = 32'd1000;
    rdata2 = 32'd16;
    tick();
    rdata1 = 32'd9;
    rdata2 = 32'd4;
    n = 0;
    while (stall && n < 100) begin
      n++;
      tick();
    end
    check("b2b stall cycles", n, 32'd33);
    check("b2b idle busy", {31'd0, busy}, 32'd0);
    check("b2b first lo", hilo_out, 32'd62);
    funct = F_MFHI;
    #1;
    check("b2b first hi", hilo_out, 32'd8);
    funct = F_DIVU;
    #1;
    tick();
    valid = 1'b0;
    funct = 6'd0;
    check("b2b second busy", {31'd0, busy}, 32'd1);
    wait_idle(n);
    check("b2b second latency", n, 32'd33);
    read_hilo("b2b second", 32'd1, 32'd2);
    tick();

    // Reset in the 10th RUN cycle of a DIV
    valid  = 1'b1;
    funct  = F_DIV;
    rdata1 = 32'hFFFF_FF9C;
    rdata2 = 32'd3;
    tick();
    funct = F_ADD;
    #1;
    check("non-muldiv no stall", {31'd0, stall}, 32'd0);
    check("non-muldiv busy", {31'd0, busy}, 32'd1);
    valid = 1'b0;
    funct = 6'd0;
    repeat (9) tick();
    check("pre-reset busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    valid = 1'b1;
    funct = F_MFHI;
    #1;
    check("abort hi", hilo_out, 32'd0);
    funct = F_MFLO;
    #1;
    check("abort lo", hilo_out, 32'd0);
    check("abort stall", {31'd0, stall}, 32'd0);
    valid = 1'b0;
    funct = 6'd0;
    tick();
    tick();
    rst = 1'b0;
    run_op("post-reset multu", F_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
